// File: rtl/variable_node_update_pkg.sv
`default_nettype none
// ============================================================================
// Module      : variable_node_update_pkg
// Description : Shared definitions for the variable-node update stage:
//               FSM state encoding and IEEE-754 single-precision constants.
// Revision    : 1.0 - initial release
// ============================================================================
package variable_node_update_pkg;

  // Word layout of the floating-point values handled by this stage
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_BIAS  = 127;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hFF80_0000;

  // Update sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TOT  = 3'd1,
    ST_Q1   = 3'd2,
    ST_Q2   = 3'd3,
    ST_Q3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage : variable_node_update_pkg
`default_nettype wire

// File: rtl/variable_node_update_if.sv
`default_nettype none
// ============================================================================
// Module      : variable_node_update_if
// Description : Request / result bundle of the variable-node update stage.
//   master : drives start, sum_in, llr_in, r1..r3; observes results
//   slave  : receives the request; drives busy, done, llr_total, hard_bit,
//            q1..q3
// Revision    : 1.0 - initial release
// ============================================================================
interface variable_node_update_if #(
  parameter int W = 32
) ();

  logic         start;
  logic [W-1:0] sum_in;
  logic [W-1:0] llr_in;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic [W-1:0] r3;
  logic         busy;
  logic         done;
  logic [W-1:0] llr_total;
  logic         hard_bit;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic [W-1:0] q3;

  modport master (
    output start, sum_in, llr_in, r1, r2, r3,
    input  busy, done, llr_total, hard_bit, q1, q2, q3
  );

  modport slave (
    input  start, sum_in, llr_in, r1, r2, r3,
    output busy, done, llr_total, hard_bit, q1, q2, q3
  );

endinterface : variable_node_update_if
`default_nettype wire

// File: rtl/variable_node_update_fp_add_comb.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_comb
// Description : Combinational floating-point adder/subtractor.
//               y = a + b (sub=0) or a - b (sub=1). Subnormal inputs flush
//               to zero, alignment keeps guard/round/sticky, the result is
//               truncated toward zero, exact zero is +0, overflow gives a
//               signed infinity and underflow flushes to +0.
//   a, b : operands (W bits)
//   sub  : invert the sign of b
//   y    : result (W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_comb #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic [EXP_W+MAN_W:0] y
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = MAN_W + 4;            // hidden bit + mantissa + G/R/S
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W+1:0] XW_E     = XW[EXP_W+1:0];
  localparam logic [XW-1:0]    X_ONE    = {{(XW-1){1'b0}}, 1'b1};

  function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
    logic           found;
    logic [LZW-1:0] cnt;
    found = 1'b0;
    cnt   = '0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        found = 1'b1;
        cnt   = LZW'(XW - 1 - i);
      end
    end
    return cnt;
  endfunction

  logic             sa, sb, s_big, s_small, a_zero, b_zero, swap, eff_sub;
  logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
  logic [MAN_W-1:0] ma, mb, m_big, m_small, man_res;
  logic [XW-1:0]    big_ext, small_ext, small_al, lost_mask, diff, norm;
  logic [XW:0]      sum_ext;
  logic [LZW-1:0]   lz;
  logic [EXP_W+1:0] exp_res, lz_e;

  always_comb begin
    sa = a[W-1];
    ea = a[W-2:MAN_W];
    ma = a[MAN_W-1:0];
    sb = b[W-1] ^ sub;
    eb = b[W-2:MAN_W];
    mb = b[MAN_W-1:0];

    // Exponent field zero means zero or subnormal; both are treated as zero
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    // Larger magnitude goes on the "big" side so the difference is never negative
    swap    = ({eb, mb} > {ea, ma});
    s_big   = swap ? sb : sa;
    e_big   = swap ? eb : ea;
    m_big   = swap ? mb : ma;
    s_small = swap ? sa : sb;
    e_small = swap ? ea : eb;
    m_small = swap ? ma : mb;
    eff_sub = s_big ^ s_small;

    d         = e_big - e_small;
    big_ext   = {1'b1, m_big, 3'b000};
    small_ext = {1'b1, m_small, 3'b000};
    lost_mask = '0;
    if ({2'b00, d} >= XW_E) begin
      // Entire small operand shifted out; only its sticky contribution remains
      small_al = X_ONE;
    end else begin
      lost_mask = (X_ONE << d) - X_ONE;
      small_al  = (small_ext >> d) | {{(XW-1){1'b0}}, |(small_ext & lost_mask)};
    end

    sum_ext = {1'b0, big_ext} + {1'b0, small_al};
    diff    = big_ext - small_al;
    lz      = lzc(diff);
    norm    = diff << lz;
    lz_e    = {{(EXP_W+2-LZW){1'b0}}, lz};

    if (!eff_sub) begin
      if (sum_ext[XW]) begin
        exp_res = {2'b00, e_big} + {{(EXP_W+1){1'b0}}, 1'b1};
        man_res = sum_ext[XW-1:4];
      end else begin
        exp_res = {2'b00, e_big};
        man_res = sum_ext[XW-2:3];
      end
    end else begin
      exp_res = {2'b00, e_big} - lz_e;
      man_res = norm[XW-2:3];
    end

    if (a_zero && b_zero) begin
      y = '0;
    end else if (b_zero) begin
      y = a;
    end else if (a_zero) begin
      y = {sb, b[W-2:0]};
    end else if (eff_sub && (diff == '0)) begin
      y = '0;
    end else if (eff_sub && (lz_e >= {2'b00, e_big})) begin
      // Normalised exponent would be <= 0: below the smallest normal
      y = '0;
    end else if (exp_res >= {2'b00, EXP_ONES}) begin
      y = {s_big, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      y = {s_big, exp_res[EXP_W-1:0], man_res};
    end
  end

endmodule : fp_add_comb
`default_nettype wire

// File: rtl/variable_node_update.sv
`default_nettype none
// ============================================================================
// Module      : variable_node_update
// Description : Variable-node stage of the belief-propagation decoder.
//               Computes llr_total = llr + sum, the hard decision, and the
//               extrinsic messages q_k = llr_total - r_k using one shared
//               combinational FP adder over four sequential steps.
//   clk  : clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : request (start, sum_in, llr_in, r1..r3) and results
//          (busy, done, llr_total, hard_bit, q1..q3)
// Revision    : 1.0 - initial release
// ============================================================================
module variable_node_update
  import variable_node_update_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                         clk,
  input  logic                         clr,
  variable_node_update_if.slave        bus
);

  localparam int W = 1 + EXP_W + MAN_W;

  state_t         state_q, state_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [W-1:0]   llr_q, llr_d;
  logic [W-1:0]   r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [W-1:0]   llr_total_q, llr_total_d;
  logic           hard_bit_q, hard_bit_d;
  logic [W-1:0]   q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
  logic [W-1:0]   add_a, add_b, add_y;
  logic           add_sub;

  fp_add_comb #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_fp_add (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .y   (add_y)
  );

  // Operand steering for the shared adder, selected by the current step
  always_comb begin
    add_a   = llr_q;
    add_b   = sum_q;
    add_sub = 1'b0;
    case (state_q)
      ST_Q1: begin add_a = llr_total_q; add_b = r1_q; add_sub = 1'b1; end
      ST_Q2: begin add_a = llr_total_q; add_b = r2_q; add_sub = 1'b1; end
      ST_Q3: begin add_a = llr_total_q; add_b = r3_q; add_sub = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    llr_d       = llr_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    llr_total_d = llr_total_q;
    hard_bit_d  = hard_bit_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    q3_d        = q3_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Both accepting states latch a new request, allowing back-to-back updates
        if (bus.start) begin
          sum_d   = bus.sum_in;
          llr_d   = bus.llr_in;
          r1_d    = bus.r1;
          r2_d    = bus.r2;
          r3_d    = bus.r3;
          state_d = ST_TOT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TOT: begin
        llr_total_d = add_y;
        hard_bit_d  = add_y[W-1];
        state_d     = ST_Q1;
      end
      ST_Q1: begin
        q1_d    = add_y;
        state_d = ST_Q2;
      end
      ST_Q2: begin
        q2_d    = add_y;
        state_d = ST_Q3;
      end
      ST_Q3: begin
        q3_d    = add_y;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      llr_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      llr_total_q <= '0;
      hard_bit_q  <= 1'b0;
      q1_q        <= '0;
      q2_q        <= '0;
      q3_q        <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      llr_q       <= llr_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      llr_total_q <= llr_total_d;
      hard_bit_q  <= hard_bit_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      q3_q        <= q3_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.llr_total = llr_total_q;
  assign bus.hard_bit  = hard_bit_q;
  assign bus.q1        = q1_q;
  assign bus.q2        = q2_q;
  assign bus.q3        = q3_q;

endmodule : variable_node_update
`default_nettype wire

// File: tb/tb_variable_node_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_variable_node_update
// Description : Self-checking bench for variable_node_update. Stimulus pushes
//               hand-computed expected results into a queue; a monitor pops
//               and compares whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_variable_node_update;

  typedef struct {
    int          id;
    logic [31:0] llr, sum, r1, r2, r3;
    logic [31:0] tot;
    logic        hb;
    logic [31:0] q1, q2, q3;
  } vec_t;

  logic clk;
  logic clr;
  int   n_tests;
  int   n_fail;
  vec_t exp_q[$];

  variable_node_update_if #(.W(32)) bus ();

  variable_node_update #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input int id,
                                 input logic [31:0] llr, sum, r1, r2, r3, tot,
                                 input logic hb,
                                 input logic [31:0] q1, q2, q3);
    vec_t v;
    v.id = id; v.llr = llr; v.sum = sum; v.r1 = r1; v.r2 = r2; v.r3 = r3;
    v.tot = tot; v.hb = hb; v.q1 = q1; v.q2 = q2; v.q3 = q3;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.llr_in = v.llr;
    bus.sum_in = v.sum;
    bus.r1     = v.r1;
    bus.r2     = v.r2;
    bus.r3     = v.r3;
  endtask

  // Garbage on the inputs after acceptance must not disturb the update
  task automatic scramble();
    bus.llr_in = 32'h4123_4567;
    bus.sum_in = 32'hC0FE_DCBA;
    bus.r1     = 32'h3E99_9999;
    bus.r2     = 32'hBE4C_CCCD;
    bus.r3     = 32'h4000_0001;
  endtask

  // Issue one update from the IDLE phase and check latency and busy length
  task automatic run_update(input vec_t v);
    int   lat;
    int   busy_n;
    logic seen;
    drive(v);
    bus.start = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    seen   = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_n++;
      if (bus.done) seen = 1'b1;
    end
    chk($sformatf("u%0d latency", v.id), lat, 32'd4);
    chk($sformatf("u%0d busy_cycles", v.id), busy_n, 32'd5);
    @(posedge clk); #1;
    chk($sformatf("u%0d idle_after", v.id), {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!clr && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk($sformatf("u%0d llr_total", e.id), bus.llr_total, e.tot);
        chk($sformatf("u%0d hard_bit", e.id), {31'd0, bus.hard_bit}, {31'd0, e.hb});
        chk($sformatf("u%0d q1", e.id), bus.q1, e.q1);
        chk($sformatf("u%0d q2", e.id), bus.q2, e.q2);
        chk($sformatf("u%0d q3", e.id), bus.q3, e.q3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v_basic, v_neg, v_cancel, v_ovf, v_c;
    int   done_cyc[$];

    n_tests = 0;
    n_fail  = 0;

    v_basic  = mkvec(1, 32'h3FC0_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000, 32'hBF00_0000,
                     32'h4060_0000, 1'b0, 32'h4020_0000, 32'h4040_0000, 32'h4080_0000);
    v_neg    = mkvec(2, 32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 32'h0000_0000, 32'h3F80_0000,
                     32'hC000_0000, 1'b1, 32'h0000_0000, 32'hC000_0000, 32'hC040_0000);
    v_cancel = mkvec(3, 32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, 32'hC000_0000,
                     32'h0000_0000, 1'b0, 32'hBF80_0000, 32'h0000_0000, 32'h4000_0000);
    v_ovf    = mkvec(4, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                     32'h7F80_0000, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
    v_c      = mkvec(5, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F80_0000, 32'hC080_0000,
                     32'h4080_0000, 1'b0, 32'h0000_0000, 32'h4040_0000, 32'h4100_0000);

    clr       = 1'b1;
    bus.start = 1'b0;
    bus.llr_in = '0; bus.sum_in = '0; bus.r1 = '0; bus.r2 = '0; bus.r3 = '0;

    // Reset state
    #12;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst llr_total", bus.llr_total, 32'd0);
    chk("rst hard_bit", {31'd0, bus.hard_bit}, 32'd0);
    chk("rst q1", bus.q1, 32'd0);
    chk("rst q2", bus.q2, 32'd0);
    chk("rst q3", bus.q3, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    // Directed single updates
    run_update(v_basic);
    run_update(v_neg);
    run_update(v_cancel);
    run_update(v_ovf);

    // start pulsed during Q1 with different inputs is ignored
    v_cancel.id = 6;
    drive(v_cancel);
    bus.start = 1'b1;
    exp_q.push_back(v_cancel);
    @(posedge clk); #1;          // TOT
    bus.start = 1'b0;
    scramble();
    @(posedge clk); #1;          // Q1
    drive(v_ovf);
    bus.start = 1'b1;
    @(posedge clk); #1;          // Q2
    bus.start = 1'b0;
    @(posedge clk); #1;          // Q3
    @(posedge clk); #1;          // DONE
    chk("u6 done_at_4", {31'd0, bus.done}, 32'd1);
    @(posedge clk); #1;
    chk("u6 idle_after_ignored_start", {31'd0, bus.busy}, 32'd0);

    // Back-to-back with start held high, inputs changed after each accept
    v_basic.id = 7; v_neg.id = 8; v_c.id = 9;
    drive(v_basic);
    bus.start = 1'b1;
    exp_q.push_back(v_basic);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (bus.done) done_cyc.push_back(cyc);
      if (cyc == 0) begin drive(v_neg); exp_q.push_back(v_neg); end
      if (cyc == 5) begin drive(v_c);   exp_q.push_back(v_c);   end
      if (cyc == 10) begin bus.start = 1'b0; scramble(); end
    end
    chk("b2b done_count", done_cyc.size(), 32'd3);
    if (done_cyc.size() == 3) begin
      chk("b2b done0_cycle", done_cyc[0], 32'd4);
      chk("b2b done1_cycle", done_cyc[1], 32'd9);
      chk("b2b done2_cycle", done_cyc[2], 32'd14);
    end

    // Asynchronous reset while in Q2
    v_basic.id = 10;
    drive(v_basic);
    bus.start = 1'b1;
    @(posedge clk); #1;          // TOT
    bus.start = 1'b0;
    @(posedge clk); #1;          // Q1
    @(posedge clk); #1;          // Q2
    #2;
    clr = 1'b1;
    #1;
    chk("mid_rst busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst llr_total", bus.llr_total, 32'd0);
    chk("mid_rst hard_bit", {31'd0, bus.hard_bit}, 32'd0);
    chk("mid_rst q1", bus.q1, 32'd0);
    chk("mid_rst q2", bus.q2, 32'd0);
    chk("mid_rst q3", bus.q3, 32'd0);
    #2;
    clr = 1'b0;
    @(posedge clk); #1;
    chk("post_rst busy", {31'd0, bus.busy}, 32'd0);

    v_neg.id = 11;
    run_update(v_neg);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_variable_node_update
`default_nettype wire
